// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//   Shared definitions for the native-bus GPIO peripheral: register offsets
//   inside the 256-byte window, bus FSM state encoding, default base address
//   and small decode helpers used by the register block.
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam logic [31:0] GPIO_DEFAULT_BASE = 32'h1000_0000;

  // Byte offsets inside the register window; only bits [7:2] are decoded.
  localparam logic [7:0] GPIO_OUT_OFS  = 8'h00;
  localparam logic [7:0] GPIO_DIR_OFS  = 8'h04;
  localparam logic [7:0] GPIO_IN_OFS   = 8'h08;
  localparam logic [7:0] GPIO_IEN_OFS  = 8'h0C;
  localparam logic [7:0] GPIO_STAT_OFS = 8'h10;
  localparam logic [7:0] GPIO_SET_OFS  = 8'h14;
  localparam logic [7:0] GPIO_CLR_OFS  = 8'h18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } gpio_state_e;

  // Word-aligned offset match: byte-lane bits [1:0] are ignored.
  function automatic logic ofs_hit(input logic [7:0] addr_lo, input logic [7:0] ofs);
    return addr_lo[7:2] == ofs[7:2];
  endfunction

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
//   Two-flop synchroniser for asynchronous pin inputs followed by a third flop
//   holding the previous synchronised value, giving a one-cycle rise pulse.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     pin_i    in   WIDTH asynchronous pin levels
//     sync_o   out  WIDTH synchronised pin levels (2 cycles behind pin_i)
//     rise_o   out  WIDTH rising-edge pulses (sync_o & ~previous sync_o)
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_native_periph.sv
// -----------------------------------------------------------------------------
// gpio_native_periph
//   GPIO peripheral on the picorv32 native memory bus. Every selected access
//   takes two cycles: the accepting edge performs any write and captures read
//   data, the following cycle presents mem_ready/mem_rdata for one cycle.
//
//   Registers (word offsets in the 256-byte window at BASE_ADDR):
//     0x00 OUT  RW      0x04 DIR  RW      0x08 IN   RO (synchronised pins)
//     0x0C IEN  RW      0x10 STAT R/W1C   0x14 SET  WO   0x18 CLR  WO
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     mem_valid/addr/     native bus request (wstrb == 0 means read)
//       wdata/wstrb
//     mem_ready           one-cycle acknowledge
//     mem_rdata           read data, zero when mem_ready is low
//     gpio_in             asynchronous pin inputs
//     gpio_out, gpio_oe   pin drive value and output enable
//     irq                 level interrupt, |(STAT & IEN)
// -----------------------------------------------------------------------------
module gpio_native_periph
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = GPIO_DEFAULT_BASE,
  parameter int          N_GPIO    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  gpio_state_e       state_q, state_d;
  logic [N_GPIO-1:0] out_q, out_d;
  logic [N_GPIO-1:0] dir_q, dir_d;
  logic [N_GPIO-1:0] ien_q, ien_d;
  logic [N_GPIO-1:0] stat_q, stat_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [N_GPIO-1:0] in_sync;
  logic [N_GPIO-1:0] in_rise;
  logic [N_GPIO-1:0] w1c;
  logic [N_GPIO-1:0] rd_bits;

  logic              sel;
  logic              accept;
  logic              do_write;
  logic [31:0]       wmask32;
  logic [N_GPIO-1:0] wmask;
  logic [N_GPIO-1:0] wbits;
  logic [7:0]        addr_lo;

  gpio_sync_edge #(.WIDTH(N_GPIO)) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (gpio_in),
    .sync_o  (in_sync),
    .rise_o  (in_rise)
  );

  assign sel      = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  // A request is only taken in IDLE, so a mem_valid held through RESP
  // cannot produce a second write.
  assign accept   = (state_q == ST_IDLE) && sel;
  assign do_write = accept && (mem_wstrb != 4'b0000);
  assign addr_lo  = mem_addr[7:0];
  assign wmask32  = strb_to_mask(mem_wstrb);
  assign wmask    = wmask32[N_GPIO-1:0];
  assign wbits    = mem_wdata[N_GPIO-1:0] & wmask;

  // Upper data/mask bits have no register behind them when N_GPIO < 32.
  if (N_GPIO < 32) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^{mem_wdata[31:N_GPIO], wmask32[31:N_GPIO]};
  end

  // Bus FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sel) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux: samples register state before this edge's updates.
  always_comb begin
    rd_bits = '0;
    rdata_d = '0;
    if      (ofs_hit(addr_lo, GPIO_OUT_OFS))  rd_bits = out_q;
    else if (ofs_hit(addr_lo, GPIO_DIR_OFS))  rd_bits = dir_q;
    else if (ofs_hit(addr_lo, GPIO_IN_OFS))   rd_bits = in_sync;
    else if (ofs_hit(addr_lo, GPIO_IEN_OFS))  rd_bits = ien_q;
    else if (ofs_hit(addr_lo, GPIO_STAT_OFS)) rd_bits = stat_q;
    rdata_d[N_GPIO-1:0] = rd_bits;
  end

  // Register write effects, each gated by its byte strobes.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ien_d = ien_q;
    w1c   = '0;
    if (do_write) begin
      if      (ofs_hit(addr_lo, GPIO_OUT_OFS))  out_d = (out_q & ~wmask) | wbits;
      else if (ofs_hit(addr_lo, GPIO_DIR_OFS))  dir_d = (dir_q & ~wmask) | wbits;
      else if (ofs_hit(addr_lo, GPIO_IEN_OFS))  ien_d = (ien_q & ~wmask) | wbits;
      else if (ofs_hit(addr_lo, GPIO_STAT_OFS)) w1c   = wbits;
      else if (ofs_hit(addr_lo, GPIO_SET_OFS))  out_d = out_q | wbits;
      else if (ofs_hit(addr_lo, GPIO_CLR_OFS))  out_d = out_q & ~wbits;
    end
    // A new enabled edge outranks a simultaneous write-1-to-clear.
    stat_d = (stat_q & ~w1c) | (in_rise & ien_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      if (accept) rdata_q <= rdata_d;
    end
  end

  assign mem_ready = (state_q == ST_RESP);
  assign mem_rdata = mem_ready ? rdata_q : 32'h0;
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(stat_q & ien_q);

endmodule

// File: tb/tb_gpio_native_periph.sv
// -----------------------------------------------------------------------------
// tb_gpio_native_periph
//   Directed and randomized stimulus for gpio_native_periph. A reference model
//   of the register map and pin history predicts each bus response and pushes
//   it into a queue; a monitor pops and compares whenever mem_ready is seen,
//   and compares the pin-side outputs against the model every cycle.
// -----------------------------------------------------------------------------
module tb_gpio_native_periph;

  localparam int          N     = 8;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] PMASK = (N >= 32) ? 32'hFFFF_FFFF : ((32'h1 << N) - 32'h1);

  logic          clk;
  logic          reset_n;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_oe;
  logic          irq;

  gpio_native_periph #(.BASE_ADDR(BASE), .N_GPIO(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rd;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_out, m_dir, m_ien, m_stat;
  bit          m_resp;
  int          edge_n     = 0;
  int          hist_start = 0;
  logic [31:0] pin_log [int];
  logic [N-1:0] pins;

  // Pin level present at clock edge j; flops hold zero before the first
  // edge after reset release.
  function automatic logic [31:0] pin_at(input int j);
    if (j < hist_start || !pin_log.exists(j)) return 32'h0;
    return pin_log[j];
  endfunction

  function automatic logic [31:0] bytes_mask(input logic [3:0] s);
    logic [31:0] m = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_ien = 0; m_stat = 0; m_resp = 0;
    exp_q.delete();
  endtask

  // Advance the model across the coming clock edge using the inputs just driven.
  task automatic model_step();
    int e;
    logic [31:0] in_b, rise, mask, wv, clr, rd, ien_old;
    bit acc;
    e = edge_n + 1;
    pin_log[e] = 32'(gpio_in);
    in_b    = pin_at(e - 2);                // IN lags the pins by two edges
    rise    = in_b & ~pin_at(e - 3);
    ien_old = m_ien;
    clr     = 0;
    rd      = 0;
    acc = mem_valid && (mem_addr[31:8] == BASE[31:8]) && !m_resp;
    if (acc) begin
      case (mem_addr[7:2])
        6'h00: rd = m_out;
        6'h01: rd = m_dir;
        6'h02: rd = in_b;
        6'h03: rd = m_ien;
        6'h04: rd = m_stat;
        default: rd = 0;
      endcase
      begin
        exp_t x;
        x.rd = rd; x.due = e;
        exp_q.push_back(x);
      end
      if (mem_wstrb != 4'h0) begin
        mask = bytes_mask(mem_wstrb) & PMASK;
        wv   = mem_wdata & mask;
        case (mem_addr[7:2])
          6'h00: m_out = (m_out & ~mask) | wv;
          6'h01: m_dir = (m_dir & ~mask) | wv;
          6'h03: m_ien = (m_ien & ~mask) | wv;
          6'h04: clr   = wv;
          6'h05: m_out = m_out | wv;
          6'h06: m_out = m_out & ~wv;
          default: ;
        endcase
      end
    end
    m_stat = (m_stat & ~clr) | (rise & ien_old);
    m_resp = acc;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("rdata", mem_rdata, x.rd);
          check("ack_edge", edge_n, x.due);
        end
      end else begin
        check("rdata_idle_zero", mem_rdata, 32'h0);
        if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
          check("missing_ack", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
      end
      check("gpio_out", 32'(gpio_out), m_out);
      check("gpio_oe",  32'(gpio_oe),  m_dir);
      check("irq",      32'(irq),      32'(|(m_stat & m_ien)));
    end
  end

  // Time bound so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s);
    @(negedge clk);
    mem_valid = v; mem_addr = a; mem_wdata = wd; mem_wstrb = s; gpio_in = pins;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Request, then the RESP cycle; when hold is set mem_valid stays high with
  // altered data, so any second write would be visible.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                        input bit hold);
    step(1'b1, a, wd, s);
    step(hold, a, hold ? ~wd : wd, s);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n   = 1'b1;
    mem_valid = 1'b0;
    gpio_in   = pins;
    hist_start = edge_n + 1;
    model_step();
  endtask

  logic [7:0] ofs_tab [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

  initial begin
    mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    pins = '0; gpio_in = '0;
    model_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();

    // Reset state reads.
    check("oe_after_reset",  32'(gpio_oe), 32'h0);
    check("irq_after_reset", 32'(irq),     32'h0);
    access(BASE + 32'h00, 0, 4'h0, 0);
    access(BASE + 32'h04, 0, 4'h0, 0);
    access(BASE + 32'h10, 0, 4'h0, 0);

    // OUT / DIR / SET / CLR.
    access(BASE + 32'h00, 32'hA5, 4'hF, 0);
    check("out_write", 32'(gpio_out), 32'hA5);
    access(BASE + 32'h04, 32'hFF, 4'hF, 0);
    check("dir_write", 32'(gpio_oe), 32'hFF);
    access(BASE + 32'h14, 32'h0A, 4'hF, 0);
    check("out_set", 32'(gpio_out), 32'hAF);
    access(BASE + 32'h18, 32'h81, 4'hF, 0);
    check("out_clr", 32'(gpio_out), 32'h2E);
    access(BASE + 32'h00, 0, 4'h0, 0);

    // Byte strobes versus pin count.
    access(BASE + 32'h00, 32'h1234_56FF, 4'b0010, 0);
    check("strb_hi_ignored", 32'(gpio_out), 32'h2E);
    access(BASE + 32'h00, 32'h1234_56FF, 4'b0001, 0);
    check("strb_lo_write", 32'(gpio_out), 32'hFF);

    // Input path and rising-edge status.
    access(BASE + 32'h0C, 32'h01, 4'hF, 0);
    pins = '0;
    idle(3);
    pins = N'(3);
    idle(2);
    access(BASE + 32'h08, 0, 4'h0, 0);
    check("irq_after_edge", 32'(irq), 32'h1);
    access(BASE + 32'h10, 0, 4'h0, 0);

    // W1C colliding with a new edge on the same bit.
    pins = N'(2);
    idle(3);
    pins = N'(3);
    idle(2);
    access(BASE + 32'h10, 32'h01, 4'hF, 0);
    check("irq_set_wins", 32'(irq), 32'h1);
    access(BASE + 32'h10, 0, 4'h0, 0);
    access(BASE + 32'h10, 32'h01, 4'hF, 0);
    check("irq_cleared", 32'(irq), 32'h0);
    access(BASE + 32'h10, 0, 4'h0, 0);

    // Held mem_valid gives a single write; unmapped offset still acknowledged.
    access(BASE + 32'h18, 32'hFF, 4'hF, 0);
    access(BASE + 32'h14, 32'h01, 4'hF, 1);
    check("held_single_set", 32'(gpio_out), 32'h01);
    idle(1);
    access(BASE + 32'h40, 32'hFF, 4'hF, 0);
    access(BASE + 32'h40, 0, 4'h0, 0);
    check("unmapped_no_effect", 32'(gpio_out), 32'h01);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      if ($urandom_range(0, 2) == 0) pins = N'($urandom);
      a = BASE | 32'(ofs_tab[$urandom_range(0, 8)]) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = BASE | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      access(a, $urandom, s, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset asserted while the response is on the bus.
    idle(2);
    access(BASE + 32'h04, 32'h3C, 4'hF, 0);
    step(1'b1, BASE + 32'h14, 32'h5A, 4'hF);
    @(posedge clk);
    #3;
    check("ready_in_resp", 32'(mem_ready), 32'h1);
    check("set_committed", 32'(gpio_out), m_out);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("ready_drops_on_reset", 32'(mem_ready), 32'h0);
    check("out_cleared",  32'(gpio_out), 32'h0);
    check("oe_cleared",   32'(gpio_oe),  32'h0);
    check("irq_cleared_rst", 32'(irq),   32'h0);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    access(BASE + 32'h00, 0, 4'h0, 0);
    access(BASE + 32'h10, 0, 4'h0, 0);
    access(BASE + 32'h0C, 0, 4'h0, 0);

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
